// File: rtl/leaf_pkg.sv
// Shared types and constants for the leaf pair arbiter: flit format, arbiter
// states and the saturating drop-counter helper.
package leaf_pkg;

    localparam int FLIT_W    = 49;
    localparam int VALID_BIT = 48;
    localparam int DROP_W    = 8;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    localparam flit_t VALID_MASK = flit_t'(1) << VALID_BIT;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/leaf_flit_fifo.sv
// Synchronous flit FIFO with a combinational head. A write on a full FIFO is
// only issued by the parent together with a read, so the freed slot is reused.
module leaf_flit_fifo
    import leaf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en_i,
    input  logic [FLIT_W-1:0]       wr_data_i,
    input  logic                    rd_en_i,
    output logic [FLIT_W-1:0]       rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    flit_t           mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/leaf_pair_arbiter.sv
// Merges the flit streams of two leaf pages onto one BFT leaf port with
// round-robin arbitration, per-page FIFOs, hold/resend back-pressure and fan-out.
module leaf_pair_arbiter
    import leaf_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [FLIT_W-1:0]   din_leaf_bft2interface,
    output logic [FLIT_W-1:0]   dout_leaf_interface2bft,
    input  logic                bft_ready,
    output logic [FLIT_W-1:0]   din_leaf_bft2interface_0,
    output logic [FLIT_W-1:0]   din_leaf_bft2interface_1,
    input  logic [FLIT_W-1:0]   dout_leaf_interface2bft_0,
    input  logic [FLIT_W-1:0]   dout_leaf_interface2bft_1,
    output logic                hold_0,
    output logic                hold_1,
    output logic                resend_0,
    output logic                resend_1,
    output logic [DROP_W-1:0]   drop_cnt_0,
    output logic [DROP_W-1:0]   drop_cnt_1
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] HOLD_TH = CW'(DEPTH - AF_MARGIN);

    flit_t              head0, head1;
    logic [CW-1:0]      cnt0, cnt1, cnt0_nxt, cnt1_nxt;
    logic               full0, full1, empty0, empty1;
    logic               vld0, vld1, wr0, wr1, drop0, drop1;
    logic               pop0, pop1, prefer1;

    arb_state_e         state_q;
    logic               last_q;
    flit_t              dout_q, fan_q;
    logic               hold0_q, hold1_q, resend0_q, resend1_q;
    logic [DROP_W-1:0]  drop0_q, drop1_q;

    leaf_flit_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr0),
        .wr_data_i (dout_leaf_interface2bft_0),
        .rd_en_i   (pop0),
        .rd_data_o (head0),
        .count_o   (cnt0),
        .full_o    (full0),
        .empty_o   (empty0)
    );

    leaf_flit_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr1),
        .wr_data_i (dout_leaf_interface2bft_1),
        .rd_en_i   (pop1),
        .rd_data_o (head1),
        .count_o   (cnt1),
        .full_o    (full1),
        .empty_o   (empty1)
    );

    // Page 1 is preferred whenever page 0 was served last; after reset last = 1.
    always_comb begin
        prefer1 = (state_q == GRANT0) || ((state_q == IDLE) && !last_q);
        pop0    = 1'b0;
        pop1    = 1'b0;
        if (bft_ready) begin
            if (!empty0 && !empty1) begin
                pop1 = prefer1;
                pop0 = !prefer1;
            end else begin
                pop0 = !empty0;
                pop1 = !empty1;
            end
        end
    end

    // A pop in the same edge frees the slot a write to a full FIFO needs.
    assign vld0     = dout_leaf_interface2bft_0[VALID_BIT];
    assign vld1     = dout_leaf_interface2bft_1[VALID_BIT];
    assign wr0      = vld0 && (!full0 || pop0);
    assign wr1      = vld1 && (!full1 || pop1);
    assign drop0    = vld0 && !wr0;
    assign drop1    = vld1 && !wr1;
    assign cnt0_nxt = cnt0 + CW'(wr0) - CW'(pop0);
    assign cnt1_nxt = cnt1 + CW'(wr1) - CW'(pop1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            dout_q  <= '0;
        end else if (bft_ready) begin
            if (pop0) begin
                state_q <= GRANT0;
                last_q  <= 1'b0;
                dout_q  <= head0 | VALID_MASK;
            end else if (pop1) begin
                state_q <= GRANT1;
                last_q  <= 1'b1;
                dout_q  <= head1 | VALID_MASK;
            end else begin
                state_q <= IDLE;
                dout_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fan_q     <= '0;
            hold0_q   <= 1'b0;
            hold1_q   <= 1'b0;
            resend0_q <= 1'b0;
            resend1_q <= 1'b0;
            drop0_q   <= '0;
            drop1_q   <= '0;
        end else begin
            fan_q     <= din_leaf_bft2interface;
            hold0_q   <= (cnt0_nxt >= HOLD_TH);
            hold1_q   <= (cnt1_nxt >= HOLD_TH);
            resend0_q <= drop0;
            resend1_q <= drop1;
            if (drop0) drop0_q <= sat_inc(drop0_q);
            if (drop1) drop1_q <= sat_inc(drop1_q);
        end
    end

    assign dout_leaf_interface2bft  = dout_q;
    assign din_leaf_bft2interface_0 = fan_q;
    assign din_leaf_bft2interface_1 = fan_q;
    assign hold_0                   = hold0_q;
    assign hold_1                   = hold1_q;
    assign resend_0                 = resend0_q;
    assign resend_1                 = resend1_q;
    assign drop_cnt_0               = drop0_q;
    assign drop_cnt_1               = drop1_q;

endmodule

// File: tb/tb_leaf_pair_arbiter.sv
// Bench for leaf_pair_arbiter: cycle-table vectors followed by scoreboarded
// sequences for contention, back-pressure, full+pop and reset mid-traffic.
module tb_leaf_pair_arbiter;

    localparam logic [48:0] V = 49'h1_0000_0000_0000;
    localparam logic [48:0] FANV = 49'h1_2345_6789_ABCD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [48:0] bft_in = '0;
    logic [48:0] dout;
    logic        bft_ready = 1'b0;
    logic [48:0] fan0, fan1;
    logic [48:0] p0 = '0;
    logic [48:0] p1 = '0;
    logic        hold0, hold1, rs0, rs1;
    logic [7:0]  dc0, dc1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [48:0] sb_q[$];
    logic        sb_en = 1'b0;

    typedef struct {
        logic [48:0] p0;
        logic [48:0] p1;
        logic [48:0] bft;
        logic        rdy;
        logic [48:0] exp_dout;
        logic [48:0] exp_fan;
    } vec_t;

    vec_t vecs[14];

    leaf_pair_arbiter #(.DEPTH(8), .AF_MARGIN(2)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .din_leaf_bft2interface    (bft_in),
        .dout_leaf_interface2bft   (dout),
        .bft_ready                 (bft_ready),
        .din_leaf_bft2interface_0  (fan0),
        .din_leaf_bft2interface_1  (fan1),
        .dout_leaf_interface2bft_0 (p0),
        .dout_leaf_interface2bft_1 (p1),
        .hold_0                    (hold0),
        .hold_1                    (hold1),
        .resend_0                  (rs0),
        .resend_1                  (rs1),
        .drop_cnt_0                (dc0),
        .drop_cnt_1                (dc1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [48:0] a, input logic [48:0] b, input logic [48:0] f,
                                input logic r, input logic [48:0] ed, input logic [48:0] ef);
        vec_t v;
        v.p0 = a; v.p1 = b; v.bft = f; v.rdy = r; v.exp_dout = ed; v.exp_fan = ef;
        return v;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        p0 = '0; p1 = '0; bft_in = '0; bft_ready = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d flits outstanding, expected 0", name, sb_q.size());
        end
    endtask

    // Compares every freshly loaded output flit against the expected order.
    initial begin
        logic rdy_s;
        logic [48:0] e;
        forever begin
            @(posedge clk);
            rdy_s = bft_ready;
            #1;
            if (sb_en && reset_n && rdy_s && dout[48]) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, expected no flit", dout);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_flit", 64'(dout), 64'(e));
                end
            end
        end
    end

    initial begin
        logic [48:0] f;

        vecs[0]  = mk(V|49'hAA, '0, FANV, 1'b1, '0, FANV);
        vecs[1]  = mk(V|49'hAB, '0, '0, 1'b1, V|49'hAA, '0);
        vecs[2]  = mk(V|49'hAC, '0, '0, 1'b1, V|49'hAB, '0);
        vecs[3]  = mk(V|49'hAD, '0, '0, 1'b1, V|49'hAC, '0);
        vecs[4]  = mk('0, '0, '0, 1'b1, V|49'hAD, '0);
        vecs[5]  = mk('0, '0, '0, 1'b1, '0, '0);
        vecs[6]  = mk(V|49'h10, V|49'h20, '0, 1'b1, '0, '0);
        vecs[7]  = mk(V|49'h11, V|49'h21, '0, 1'b1, V|49'h20, '0);
        vecs[8]  = mk(V|49'h12, V|49'h22, '0, 1'b1, V|49'h10, '0);
        vecs[9]  = mk('0, '0, '0, 1'b1, V|49'h21, '0);
        vecs[10] = mk('0, '0, '0, 1'b1, V|49'h11, '0);
        vecs[11] = mk('0, '0, '0, 1'b1, V|49'h22, '0);
        vecs[12] = mk('0, '0, '0, 1'b1, V|49'h12, '0);
        vecs[13] = mk('0, '0, '0, 1'b1, '0, '0);

        do_reset();
        #1;
        check("rst_dout", 64'(dout), 64'h0);
        check("rst_flags", 64'({hold0, hold1, rs0, rs1}), 64'h0);
        check("rst_drop", 64'({dc0, dc1}), 64'h0);
        check("rst_fan", 64'({fan0, fan1}), 64'h0);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            p0 = vecs[i].p0; p1 = vecs[i].p1; bft_in = vecs[i].bft; bft_ready = vecs[i].rdy;
            @(posedge clk); #1;
            check($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
            check($sformatf("vec%0d_fan", i), 64'({fan0, fan1}), 64'({vecs[i].exp_fan, vecs[i].exp_fan}));
            check($sformatf("vec%0d_flags", i), 64'({hold0, hold1, rs0, rs1}), 64'h0);
            @(negedge clk);
        end

        // Contention straight after reset: page 0 first, then strict alternation.
        do_reset();
        sb_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            p0 = V | (49'h400 + 49'(k));
            p1 = V | (49'h500 + 49'(k));
            sb_q.push_back(p0);
            sb_q.push_back(p1);
            bft_ready = 1'b1;
            @(negedge clk);
        end
        p0 = '0; p1 = '0;
        wait_drain("cont_drain");

        // Back-pressure: 10 flits into FIFO 1 with the BFT stalled for 12 cycles.
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            bft_ready = 1'b0;
            if (k <= 10) begin
                f = V | (49'h100 + 49'(k));
                p1 = f;
                if (k <= 8) sb_q.push_back(f);
            end else begin
                p1 = '0;
            end
            @(posedge clk); #1;
            check($sformatf("bp_hold1_k%0d", k), 64'(hold1), 64'(k >= 6));
            check($sformatf("bp_resend1_k%0d", k), 64'(rs1), 64'(k == 9 || k == 10));
            check($sformatf("bp_drop1_k%0d", k), 64'(dc1), (k <= 8) ? 64'd0 : (k == 9) ? 64'd1 : 64'd2);
            @(negedge clk);
        end
        bft_ready = 1'b1;
        wait_drain("bp_drain");
        repeat (2) @(negedge clk);
        check("bp_hold1_released", 64'(hold1), 64'h0);

        // Fill FIFO 0, then pop and push in the same edge.
        bft_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p0 = V | (49'h200 + 49'(k));
            sb_q.push_back(p0);
            @(negedge clk);
        end
        p0 = '0;
        #1;
        check("fp_hold0_full", 64'(hold0), 64'h1);
        @(negedge clk);
        p0 = V | 49'h208;
        sb_q.push_back(p0);
        bft_ready = 1'b1;
        @(posedge clk); #1;
        check("fp_resend0", 64'(rs0), 64'h0);
        check("fp_drop0", 64'(dc0), 64'h0);
        check("fp_hold0", 64'(hold0), 64'h1);
        @(negedge clk);
        p0 = '0;
        bft_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("fp_out_held", 64'(dout), 64'(V | 49'h200));
            @(negedge clk);
        end
        bft_ready = 1'b1;
        wait_drain("fp_drain");

        // Reset with three flits still queued in FIFO 0.
        @(negedge clk);
        bft_ready = 1'b0;
        bft_in = V | 49'h77;
        for (int k = 0; k < 4; k++) begin
            p0 = V | (49'h300 + 49'(k));
            @(negedge clk);
        end
        p0 = '0;
        sb_q.push_back(V | 49'h300);
        bft_ready = 1'b1;
        @(posedge clk); #1;
        check("rm_pre_dout", 64'(dout), 64'(V | 49'h300));
        @(negedge clk);
        bft_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rm_dout", 64'(dout), 64'h0);
        check("rm_fan", 64'({fan0, fan1}), 64'h0);
        check("rm_drop", 64'({dc0, dc1}), 64'h0);
        check("rm_flags", 64'({hold0, hold1, rs0, rs1}), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bft_in = '0;
        bft_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("rm_no_stale", 64'(dout), 64'h0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
